// File: rtl/logic_dispatch_if.sv
// Operation handshake bundle for logic_dispatch: upstream op offer and the registered
// controls/operands presented downstream. err exists only with LOGIC_DISPATCH_ILLEGAL_EN.
interface logic_dispatch_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             c_and;
    logic             c_or;
    logic             c_xor;
    logic             c_inv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef LOGIC_DISPATCH_ILLEGAL_EN
    logic             err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, c_and, c_or, c_xor, c_inv, a, b, err
    );
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, c_and, c_or, c_xor, c_inv, a, b, err
    );
`else
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, c_and, c_or, c_xor, c_inv, a, b
    );
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, c_and, c_or, c_xor, c_inv, a, b
    );
`endif
endinterface

// File: rtl/logic_dispatch.sv
// Decodes logic opcodes into one-hot function selects behind an OUT register plus skid slot.
// Optional macro LOGIC_DISPATCH_ILLEGAL_EN: ops 6/7 are swallowed and raise a sticky err.
module logic_dispatch #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    logic_dispatch_if.slave       bus,
    output logic                  skid_full
);
    // Handshake: a beat moves when valid && ready on the same rising edge; valid never
    // waits on ready, and in_ready is a pure flop output (no path from out_ready).
    typedef struct packed {
        logic             c_and;
        logic             c_or;
        logic             c_xor;
        logic             c_inv;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } payload_t;

    payload_t out_q, skid_q, in_pl;
    logic     out_valid_q, skid_full_q, in_ready_q;
    logic     out_valid_d, skid_full_d;
    logic     accept, drain, fwd;
    logic     load_out_in, load_out_skid, load_skid;

    always_comb begin
        in_pl   = '0;
        in_pl.a = bus.in_a;
        in_pl.b = bus.in_b;
        case (bus.in_op)
            3'd0: in_pl.c_and = 1'b1;
            3'd1: in_pl.c_or  = 1'b1;
            3'd2: in_pl.c_xor = 1'b1;
            3'd3: begin in_pl.c_and = 1'b1; in_pl.c_inv = 1'b1; end
            3'd4: begin in_pl.c_or  = 1'b1; in_pl.c_inv = 1'b1; end
            3'd5: begin in_pl.c_xor = 1'b1; in_pl.c_inv = 1'b1; end
            default: ;
        endcase
    end

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

`ifdef LOGIC_DISPATCH_ILLEGAL_EN
    logic illegal;
    logic err_q;
    assign illegal = bus.in_op[2] && bus.in_op[1];
    assign fwd     = accept && !illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err_q <= 1'b0;
        else if (accept && illegal) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign fwd = accept;
`endif

    always_comb begin
        out_valid_d   = out_valid_q;
        skid_full_d   = skid_full_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (skid_full_q) begin
            // in_ready is low here, so only the skid-to-OUT move can happen
            if (drain) begin
                load_out_skid = 1'b1;
                skid_full_d   = 1'b0;
            end
        end else if (fwd) begin
            if (!out_valid_q || drain) begin
                load_out_in = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                load_skid   = 1'b1;
                skid_full_d = 1'b1;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= !skid_full_d;
            if (load_out_in)        out_q <= in_pl;
            else if (load_out_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= in_pl;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.c_and     = out_q.c_and;
    assign bus.c_or      = out_q.c_or;
    assign bus.c_xor     = out_q.c_xor;
    assign bus.c_inv     = out_q.c_inv;
    assign bus.a         = out_q.a;
    assign bus.b         = out_q.b;
    assign skid_full     = skid_full_q;
endmodule

// File: tb/tb_logic_dispatch.sv
// Directed bench for logic_dispatch (WIDTH=8): reset, decode, skid, streaming,
// random back-pressure with an expected queue, illegal ops, and mid-operation reset.
module tb_logic_dispatch;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic skid_full;
    int   checks;
    int   failures;

    logic_dispatch_if #(.WIDTH(W)) bus ();

    logic_dispatch #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .skid_full (skid_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {c_and, c_or, c_xor, c_inv} per opcode
    logic [3:0] exp_ctrl [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001,
                                 4'b0101, 4'b0011, 4'b0000, 4'b0000};
    logic [3+2*W:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a_v;
        bus.in_b     = b_v;
    endtask

    function automatic logic [3:0] ctrl_now();
        return {bus.c_and, bus.c_or, bus.c_xor, bus.c_inv};
    endfunction

    initial begin
        int sent, got, cyc;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        logic [3+2*W:0] e;
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_skid_full", skid_full, 0);
        chk("rst_ctrl", ctrl_now(), 4'b0000);
        chk("rst_ab", {bus.a, bus.b}, 16'h0000);
`ifdef LOGIC_DISPATCH_ILLEGAL_EN
        chk("rst_err", bus.err, 0);
`endif
        rst_n = 1'b1;
        chk("rel_in_ready_before_edge", bus.in_ready, 0);
        step();
        chk("rel_in_ready_after_edge", bus.in_ready, 1);

        // NAND single op, one-cycle latency
        bus.out_ready = 1'b1;
        offer(3'd3, 8'hF0, 8'h3C);
        step();
        bus.in_valid = 1'b0;
        chk("nand_out_valid", bus.out_valid, 1);
        chk("nand_ctrl", ctrl_now(), 4'b1001);
        chk("nand_ab", {bus.a, bus.b}, 16'hF03C);
        step();
        chk("nand_drained", bus.out_valid, 0);
        chk("idle_hold_ab", {bus.a, bus.b}, 16'hF03C);
        chk("idle_hold_ctrl", ctrl_now(), 4'b1001);

        // skid fill under back-pressure, then ordered drain
        bus.out_ready = 1'b0;
        offer(3'd0, 8'h11, 8'h22);
        step();
        chk("skid_first_in_ready", bus.in_ready, 1);
        offer(3'd1, 8'h33, 8'h44);
        step();
        bus.in_valid = 1'b0;
        chk("skid_full_set", skid_full, 1);
        chk("skid_in_ready_low", bus.in_ready, 0);
        chk("skid_out_ctrl", ctrl_now(), 4'b1000);
        step();
        chk("stall_stable_ab", {bus.a, bus.b}, 16'h1122);
        chk("stall_stable_ctrl", ctrl_now(), 4'b1000);
        bus.out_ready = 1'b1;
        step();
        chk("skid_move_valid", bus.out_valid, 1);
        chk("skid_move_ctrl", ctrl_now(), 4'b0100);
        chk("skid_move_ab", {bus.a, bus.b}, 16'h3344);
        chk("skid_cleared", skid_full, 0);
        chk("skid_in_ready_back", bus.in_ready, 1);
        step();
        chk("skid_all_drained", bus.out_valid, 0);

        // continuous stream of 16 ops, ops 0..5 cyclic
        for (int i = 0; i < 16; i++) begin
            offer(3'(i % 6), 8'(i), 8'(~i));
            step();
            chk("stream_in_ready", bus.in_ready, 1);
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_ctrl", ctrl_now(), exp_ctrl[i % 6]);
            chk("stream_ab", {bus.a, bus.b}, {8'(i), 8'(~i)});
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_end_idle", bus.out_valid, 0);

        // random back-pressure, random operands, 200 ops through the expected queue
        sent = 0; got = 0; cyc = 0;
        while ((sent < 200 || exp_q.size() != 0) && cyc < 4000) begin
            if (!bus.in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                rop = 3'($urandom_range(0, 5));
                ra  = 8'($urandom_range(0, 255));
                rb  = 8'($urandom_range(0, 255));
                offer(rop, ra, rb);
            end
            bus.out_ready = (sent >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                chk("rand_unexpected_out", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rand_out", {ctrl_now(), bus.a, bus.b}, e);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({exp_ctrl[bus.in_op], bus.in_a, bus.in_b});
                sent++;
                step();
                bus.in_valid = 1'b0;
            end else begin
                step();
            end
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("rand_sent", sent, 200);
        chk("rand_received", got, 200);
        chk("rand_queue_empty", exp_q.size(), 0);
        step();

        // reserved opcode behaviour
        bus.out_ready = 1'b1;
`ifdef LOGIC_DISPATCH_ILLEGAL_EN
        offer(3'd7, 8'h5A, 8'hA5);
        step();
        chk("ill_not_forwarded", bus.out_valid, 0);
        chk("ill_err_set", bus.err, 1);
        offer(3'd2, 8'h0F, 8'hF0);
        step();
        bus.in_valid = 1'b0;
        chk("ill_next_valid", bus.out_valid, 1);
        chk("ill_next_ctrl", ctrl_now(), 4'b0010);
        chk("ill_next_ab", {bus.a, bus.b}, 16'h0FF0);
        step();
        chk("ill_err_sticky", bus.err, 1);
`else
        offer(3'd7, 8'h5A, 8'hA5);
        step();
        bus.in_valid = 1'b0;
        chk("rsv_forwarded", bus.out_valid, 1);
        chk("rsv_ctrl_zero", ctrl_now(), 4'b0000);
        chk("rsv_ab", {bus.a, bus.b}, 16'h5AA5);
        step();
        chk("rsv_drained", bus.out_valid, 0);
`endif

        // reset while OUT and SKID are both occupied
        bus.out_ready = 1'b0;
        offer(3'd4, 8'h01, 8'h02);
        step();
        offer(3'd5, 8'h03, 8'h04);
        step();
        bus.in_valid = 1'b0;
        chk("midrst_skid_full", skid_full, 1);
        chk("midrst_out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_async", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_skid_clr", skid_full, 0);
        chk("midrst_ab_clr", {bus.a, bus.b}, 16'h0000);
`ifdef LOGIC_DISPATCH_ILLEGAL_EN
        chk("midrst_err_clr", bus.err, 0);
`endif
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("midrst_ready_back", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_stale", bus.out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/logic_dispatch.md
LOGIC_DISPATCH -- requirements
Module: logic_dispatch

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream offers an operation.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 in_op  input  3  opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6..7 reserved.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  registered operation is presented to the logic unit.
REQ-010 out_ready  input  1  downstream consumes the presented operation.
REQ-011 c_and, c_or, c_xor, c_inv  output  1 each  one-hot function select plus inversion, registered.
REQ-012 a, b  output  WIDTH  registered operands.
REQ-013 err  output  1  sticky illegal-opcode flag; present only with LOGIC_DISPATCH_ILLEGAL_EN.

Function
REQ-014 Handshake: transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-015 Decode: op 0/3 -> c_and; 1/4 -> c_or; 2/5 -> c_xor; c_inv=1 for op 3,4,5; exactly one of c_and/c_or/c_xor high for legal ops.
REQ-016 Storage: one output register (OUT) plus one skid register (SKID), both holding decoded controls and operands.
REQ-017 Latency: an accepted op appears at outputs the cycle after acceptance when OUT is empty or drains that same cycle.
REQ-018 in_ready driven directly from a flop: in_ready = !skid_full; no combinational path from out_ready to in_ready.
REQ-019 Accept while OUT is full and not draining: op goes to SKID; skid_full sets.
REQ-020 OUT drains with SKID full: SKID moves to OUT next cycle, skid_full clears; input is not accepted that cycle (in_ready=0).
REQ-021 OUT drains with SKID empty and accept: new op loads OUT directly; out_valid stays 1.
REQ-022 OUT drains, no accept, SKID empty: out_valid falls to 0 next cycle.
REQ-023 Ordering strictly FIFO; no op dropped or duplicated (except REQ-029).
REQ-024 Outputs c_*, a, b stable while out_valid=1 and out_ready=0.
REQ-025 With out_valid=0, c_*, a, b hold their last values.

Reset
REQ-026 While rst_n=0: out_valid=0, skid_full=0, in_ready=0, c_and=c_or=c_xor=c_inv=0, a=b=0, err=0.
REQ-027 in_ready rises on the first clock edge after rst_n deasserts; pending OUT/SKID contents are discarded on reset mid-operation.
REQ-028 Reset assertion is asynchronous; deassertion is taken synchronously to clk.

Configuration
REQ-029 Macro LOGIC_DISPATCH_ILLEGAL_EN defined: ops 6/7 are accepted (handshake completes), not forwarded, and set err, which holds until reset.
REQ-030 Macro undefined: err port absent; ops 6/7 forwarded with all four controls 0 and operands passed through.

Verification
REQ-031 Reset, then in_op=3, a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_valid=1, c_and=1, c_inv=1, a=F0, b=3C.
REQ-032 out_ready=0, send ops 0 then 1 -> second lands in SKID, in_ready=0; raise out_ready -> op 0 then op 1 emitted on consecutive cycles.
REQ-033 Continuous in_valid with out_ready=1 for 16 ops 0..5 cyclic -> 16 outputs in order, one per cycle, in_ready constant 1.
REQ-034 out_ready toggling randomly for 200 ops with random operands -> output sequence equals input sequence, no losses.
REQ-035 With macro: send op 7 then op 2 -> op 7 not emitted, err=1 permanently, op 2 emitted; without macro: op 7 emitted with all controls 0.
REQ-036 Assert rst_n=0 while OUT and SKID full -> out_valid=0 immediately; after release no stale op emitted.
